absorb_feeder: RTL and testbench
================================

// Module: absorb_feeder
// PURPOSE
//  Sequencing stage directly upstream of absorb_unit. Accepts a 256-bit message stream,
//  presents beats or stored carry-over to absorb_unit, and owns the bytes_absorbed register.
//  Raises a permutation request when a rate block fills and a padding request at message end.
//  Latches absorb_unit carry-over and replays it after each permutation.
// PARAMETERS (taken from keccak_pkg, no local overrides)
//  DWIDTH            256   message beat width, bits
//  KEEP_WIDTH        32    byte enables per beat
//  CARRY_KEEP_WIDTH  24    byte enables of carry-over (max 24 B carried)
//  RATE_WIDTH        pkg   width of rate_i (bits)
//  BYTE_ABSORB_WIDTH pkg   width of byte counters
// PORTS
//  clk                 in   1                  clock
//  rst                 in   1                  synchronous reset, active-high
//  start_i             in   1                  new message; sampled only in IDLE
//  rate_i              in   RATE_WIDTH         rate in bits (576/1088/1344); latched on start_i
//  t_valid_i           in   1                  input beat valid
//  t_ready_o           out  1                  input beat accepted when valid&ready
//  t_data_i            in   DWIDTH             beat data, byte 0 = LSB
//  t_keep_i            in   KEEP_WIDTH         contiguous LSB-first byte enables (may be 0 on last)
//  t_last_i            in   1                  final beat of message
//  msg_o               out  DWIDTH             to absorb_unit.msg_i
//  keep_o              out  KEEP_WIDTH         to absorb_unit.keep_i
//  bytes_absorbed_o    out  BYTE_ABSORB_WIDTH  registered count, to absorb_unit.bytes_absorbed_i
//  bytes_absorbed_i    in   BYTE_ABSORB_WIDTH  from absorb_unit.bytes_absorbed_o
//  carry_over_i        in   DWIDTH             from absorb_unit.carry_over_o
//  has_carry_over_i    in   1                  from absorb_unit.has_carry_over_o
//  carry_keep_i        in   CARRY_KEEP_WIDTH   from absorb_unit.carry_keep_o
//  absorb_en_o         out  1                  state register loads absorb_unit.state_array_o
//  perm_req_o          out  1                  level; rate block full, permute
//  perm_done_i         in   1                  1-cycle pulse, permutation finished
//  pad_req_o           out  1                  level; message complete, pad & finalise
//  pad_bytes_o         out  BYTE_ABSORB_WIDTH  bytes already in current block (pad offset)
//  pad_ack_i           in   1                  1-cycle pulse, padding unit took request
// BEHAVIOUR
//  - Reset: state=IDLE; count, carry regs, last_pend, rate reg = 0; every output 0.
//    rst mid-operation aborts; carry discarded; no request outputs held.
//  - States: IDLE, ABSORB, PERMUTE, CARRY, PAD.
//  - IDLE: start_i -> latch rate_bytes = rate_i>>3; count=0; last_pend=0; -> ABSORB.
//    start_i outside IDLE ignored.
//  - ABSORB: t_ready_o=1; msg_o=t_data_i, keep_o=t_keep_i.
//    absorb_en_o = t_valid_i & t_ready_o (zero-latency, absorb_unit is combinational).
//  - On accepted beat: last_pend|=t_last_i.
//    If bytes_absorbed_i==rate_bytes: count<=0; latch carry_over_i/carry_keep_i/has_carry_over_i;
//    -> PERMUTE.
//    Else count<=bytes_absorbed_i; if t_last_i -> PAD.
//  - PERMUTE: perm_req_o=1, t_ready_o=0, absorb_en_o=0. On perm_done_i: carry valid -> CARRY;
//    else last_pend -> PAD; else -> ABSORB.
//  - CARRY: one cycle. msg_o=carry data, keep_o={8'h00,carry_keep}, absorb_en_o=1;
//    count<=bytes_absorbed_i; clear carry valid.
//    Carry <=24 B < min rate 72 B, so it never re-overflows.
//    Then last_pend -> PAD, else -> ABSORB.
//  - PAD: pad_req_o=1, pad_bytes_o=count (held stable). On pad_ack_i -> IDLE, count=0.
//    A block filling exactly on the last beat gives PERMUTE then PAD with pad_bytes_o=0.
//  - msg_o/keep_o = 0 in IDLE/PERMUTE/PAD; bytes_absorbed_o = count in all states.
//  - Widths: count < rate_bytes <= 168 always; no wrap. rate_i changes outside IDLE ignored.
// TESTING
//  T1 rate 1088: 5 full 32B beats, last on 5th -> 5th absorbs 8B, count 136 -> PERMUTE, carry 24B;
//     perm_done -> CARRY (keep_o=32'h00FFFFFF) -> PAD with pad_bytes_o=24.
//  T2 rate 1088: 4x32B + 8B last -> PERMUTE, no CARRY cycle, then PAD pad_bytes_o=0.
//  T3 rate 576: 2x32B + 32B last -> 8B absorbed at 64, perm_req, carry replayed -> pad_bytes_o=24.
//  T4 empty message: start, one beat keep=0 last=1 -> PAD pad_bytes_o=0, no perm_req.
//  T5 backpressure: t_valid held high through PERMUTE (perm_done after 24 cycles)
//     -> t_ready_o=0 there, no beat lost or duplicated; count sequence matches T1.
//  T6 rst asserted in PERMUTE with carry pending -> next cycle IDLE, all outputs 0;
//     new message starts at count 0.

Source files
------------

// File: rtl/absorb_feeder.sv
// -----------------------------------------------------------------------------
// absorb_feeder
//   Sequencing stage directly upstream of absorb_unit. It takes a 256-bit
//   message stream and presents either the live beat or stored carry-over bytes
//   to absorb_unit. It also owns the bytes_absorbed count for the current rate
//   block. When a rate block fills, it raises a permutation request. When the
//   message ends, it raises a padding request. Carry-over that absorb_unit could
//   not fit into a full block is latched and replayed once the permutation has
//   finished.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i, rate_i     begin a new message; rate in bits, latched on start
//   t_valid_i/t_ready_o input beat handshake
//   t_data_i/t_keep_i   beat payload and contiguous LSB-first byte enables
//   t_last_i            final beat of the message
//   msg_o/keep_o        data and byte enables driven to absorb_unit
//   bytes_absorbed_o    registered byte count within the current block
//   bytes_absorbed_i    updated byte count computed by absorb_unit
//   carry_over_i, carry_keep_i, has_carry_over_i
//                       overflow bytes from absorb_unit
//   absorb_en_o         state register captures absorb_unit output this cycle
//   perm_req_o/perm_done_i  permutation request (level) / completion (pulse)
//   pad_req_o/pad_bytes_o/pad_ack_i
//                       padding request (level), pad offset, acceptance (pulse)
//
// Handshake: a beat transfers on any rising clk edge where t_valid_i and
// t_ready_o are both high. t_ready_o depends only on the FSM state, never on
// t_valid_i. A beat held valid while t_ready_o is low is neither consumed nor
// duplicated.
// -----------------------------------------------------------------------------
module absorb_feeder #(
  // Widths mirror keccak_pkg; they are not meant to be overridden.
  localparam int DWIDTH            = 256,
  localparam int KEEP_WIDTH        = 32,
  localparam int CARRY_KEEP_WIDTH  = 24,
  localparam int RATE_WIDTH        = 11,
  localparam int BYTE_ABSORB_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [RATE_WIDTH-1:0]        rate_i,
  input  logic                         t_valid_i,
  output logic                         t_ready_o,
  input  logic [DWIDTH-1:0]            t_data_i,
  input  logic [KEEP_WIDTH-1:0]        t_keep_i,
  input  logic                         t_last_i,
  output logic [DWIDTH-1:0]            msg_o,
  output logic [KEEP_WIDTH-1:0]        keep_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] bytes_absorbed_o,
  input  logic [BYTE_ABSORB_WIDTH-1:0] bytes_absorbed_i,
  input  logic [DWIDTH-1:0]            carry_over_i,
  input  logic                         has_carry_over_i,
  input  logic [CARRY_KEEP_WIDTH-1:0]  carry_keep_i,
  output logic                         absorb_en_o,
  output logic                         perm_req_o,
  input  logic                         perm_done_i,
  output logic                         pad_req_o,
  output logic [BYTE_ABSORB_WIDTH-1:0] pad_bytes_o,
  input  logic                         pad_ack_i
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ABSORB  = 3'd1,
    ST_PERMUTE = 3'd2,
    ST_CARRY   = 3'd3,
    ST_PAD     = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [BYTE_ABSORB_WIDTH-1:0]   count_q, count_d;
  // Rate in bytes. Kept at rate_i width so the shifted value is stored without
  // truncation; the upper bits are always zero for the legal rates.
  logic [RATE_WIDTH-1:0]          rate_bytes_q, rate_bytes_d;
  logic [DWIDTH-1:0]              carry_data_q, carry_data_d;
  logic [CARRY_KEEP_WIDTH-1:0]    carry_keep_q, carry_keep_d;
  logic                           carry_vld_q, carry_vld_d;
  logic                           last_pend_q, last_pend_d;

  // A full block is detected when absorb_unit reports the rate as its new
  // count. Its own count never exceeds the rate.
  logic block_full;
  assign block_full =
    ({{(RATE_WIDTH-BYTE_ABSORB_WIDTH){1'b0}}, bytes_absorbed_i} == rate_bytes_q);

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rate_bytes_d = rate_bytes_q;
    carry_data_d = carry_data_q;
    carry_keep_d = carry_keep_q;
    carry_vld_d  = carry_vld_q;
    last_pend_d  = last_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rate_bytes_d = rate_i >> 3;
          count_d      = '0;
          last_pend_d  = 1'b0;
          state_d      = ST_ABSORB;
        end
      end

      ST_ABSORB: begin
        if (t_valid_i) begin
          last_pend_d = last_pend_q | t_last_i;
          if (block_full) begin
            count_d      = '0;
            carry_data_d = carry_over_i;
            carry_keep_d = carry_keep_i;
            carry_vld_d  = has_carry_over_i;
            state_d      = ST_PERMUTE;
          end else begin
            count_d = bytes_absorbed_i;
            if (t_last_i) state_d = ST_PAD;
          end
        end
      end

      ST_PERMUTE: begin
        if (perm_done_i) begin
          if (carry_vld_q)      state_d = ST_CARRY;
          else if (last_pend_q) state_d = ST_PAD;
          else                  state_d = ST_ABSORB;
        end
      end

      // Carry-over is at most 24 bytes and the smallest rate is 72 bytes, so a
      // replay can never fill a block. A single cycle is always enough.
      ST_CARRY: begin
        count_d     = bytes_absorbed_i;
        carry_vld_d = 1'b0;
        state_d     = last_pend_q ? ST_PAD : ST_ABSORB;
      end

      ST_PAD: begin
        if (pad_ack_i) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      rate_bytes_q <= '0;
      carry_data_q <= '0;
      carry_keep_q <= '0;
      carry_vld_q  <= 1'b0;
      last_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rate_bytes_q <= rate_bytes_d;
      carry_data_q <= carry_data_d;
      carry_keep_q <= carry_keep_d;
      carry_vld_q  <= carry_vld_d;
      last_pend_q  <= last_pend_d;
    end
  end

  // Output decode. The outputs depend only on registered state, except for the
  // zero-latency pass-through of the live beat in ABSORB.
  always_comb begin
    t_ready_o   = 1'b0;
    msg_o       = '0;
    keep_o      = '0;
    absorb_en_o = 1'b0;
    perm_req_o  = 1'b0;
    pad_req_o   = 1'b0;
    pad_bytes_o = '0;

    case (state_q)
      ST_ABSORB: begin
        t_ready_o   = 1'b1;
        msg_o       = t_data_i;
        keep_o      = t_keep_i;
        absorb_en_o = t_valid_i;
      end
      ST_PERMUTE: perm_req_o = 1'b1;
      ST_CARRY: begin
        msg_o       = carry_data_q;
        keep_o      = {{(KEEP_WIDTH-CARRY_KEEP_WIDTH){1'b0}}, carry_keep_q};
        absorb_en_o = 1'b1;
      end
      ST_PAD: begin
        pad_req_o   = 1'b1;
        pad_bytes_o = count_q;
      end
      default: ;
    endcase
  end

  assign bytes_absorbed_o = count_q;

endmodule

// File: tb/tb_absorb_feeder.sv
// -----------------------------------------------------------------------------
// tb_absorb_feeder
//   Directed bench for absorb_feeder. A small behavioural stand-in for
//   absorb_unit computes the updated count and the carry-over from the feeder's
//   outputs. Each expected value is computed by hand from the test scenario.
// -----------------------------------------------------------------------------
module tb_absorb_feeder;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DUT signals
  logic         start_i;
  logic [10:0]  rate_i;
  logic         t_valid_i, t_ready_o, t_last_i;
  logic [255:0] t_data_i, msg_o, carry_over_i;
  logic [31:0]  t_keep_i, keep_o;
  logic [7:0]   bytes_absorbed_o, bytes_absorbed_i, pad_bytes_o;
  logic         has_carry_over_i;
  logic [23:0]  carry_keep_i;
  logic         absorb_en_o, perm_req_o, perm_done_i, pad_req_o, pad_ack_i;

  absorb_feeder dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .rate_i           (rate_i),
    .t_valid_i        (t_valid_i),
    .t_ready_o        (t_ready_o),
    .t_data_i         (t_data_i),
    .t_keep_i         (t_keep_i),
    .t_last_i         (t_last_i),
    .msg_o            (msg_o),
    .keep_o           (keep_o),
    .bytes_absorbed_o (bytes_absorbed_o),
    .bytes_absorbed_i (bytes_absorbed_i),
    .carry_over_i     (carry_over_i),
    .has_carry_over_i (has_carry_over_i),
    .carry_keep_i     (carry_keep_i),
    .absorb_en_o      (absorb_en_o),
    .perm_req_o       (perm_req_o),
    .perm_done_i      (perm_done_i),
    .pad_req_o        (pad_req_o),
    .pad_bytes_o      (pad_bytes_o),
    .pad_ack_i        (pad_ack_i)
  );

  // absorb_unit stand-in: count + kept bytes, clamped at the rate; any excess
  // bytes become carry-over, shifted down to byte 0.
  int rate_m;
  int nb, sum, off;
  always_comb begin
    nb               = $countones(keep_o);
    sum              = int'(bytes_absorbed_o) + nb;
    off              = 0;
    bytes_absorbed_i = 8'(sum);
    carry_over_i     = '0;
    carry_keep_i     = '0;
    has_carry_over_i = 1'b0;
    if (rate_m > 0 && sum >= rate_m) begin
      bytes_absorbed_i = 8'(rate_m);
      off              = rate_m - int'(bytes_absorbed_o);
      carry_over_i     = msg_o >> (8 * off);
      carry_keep_i     = 24'((64'h1 << (sum - rate_m)) - 64'h1);
      has_carry_over_i = (sum > rate_m);
    end
  end

  // Event monitor: counts accepted beats and cycles with perm_req_o high.
  int acc_cnt  = 0;
  int perm_cyc = 0;
  always @(posedge clk) begin
    if (t_valid_i && t_ready_o) acc_cnt <= acc_cnt + 1;
    if (perm_req_o)             perm_cyc <= perm_cyc + 1;
  end

  // Scoreboard counters
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_data(input int seed);
    logic [255:0] d;
    for (int k = 0; k < 32; k++) d[8*k +: 8] = 8'(seed + k);
    return d;
  endfunction

  function automatic logic [31:0] mk_keep(input int n);
    return 32'((64'h1 << n) - 64'h1);
  endfunction

  task automatic start_msg(input int rate_bits);
    rate_i  = 11'(rate_bits);
    rate_m  = rate_bits / 8;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    rate_i  = '0;  // later changes must be ignored
  endtask

  task automatic send_beat(input logic [255:0] data, input int n, input logic last);
    int waited;
    waited    = 0;
    t_valid_i = 1'b1;
    t_data_i  = data;
    t_keep_i  = mk_keep(n);
    t_last_i  = last;
    #1;
    while (!t_ready_o && waited < 100) begin
      tick();
      waited++;
    end
    check("beat_accept_in_budget", 256'(waited < 100), 256'(1));
    tick();
    t_valid_i = 1'b0;
    t_data_i  = '0;
    t_keep_i  = '0;
    t_last_i  = 1'b0;
  endtask

  task automatic pulse_perm_done();
    perm_done_i = 1'b1;
    tick();
    perm_done_i = 1'b0;
  endtask

  task automatic pulse_pad_ack();
    pad_ack_i = 1'b1;
    tick();
    pad_ack_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},     t_ready_o,        0);
    check({tag, "_perm_req"},  perm_req_o,       0);
    check({tag, "_pad_req"},   pad_req_o,        0);
    check({tag, "_absorb_en"}, absorb_en_o,      0);
    check({tag, "_count"},     bytes_absorbed_o, 0);
    check({tag, "_pad_bytes"}, pad_bytes_o,      0);
    check({tag, "_msg"},       msg_o,            0);
    check({tag, "_keep"},      keep_o,           0);
  endtask

  // Global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: observed stuck expected finish");
    $fatal(1, "time limit");
  end

  // Directed sequence
  logic [255:0] d5, d6;
  int a_base, p_base;

  initial begin
    rst = 1'b1; start_i = 0; rate_i = 0; t_valid_i = 0; t_data_i = 0;
    t_keep_i = 0; t_last_i = 0; perm_done_i = 0; pad_ack_i = 0; rate_m = 0;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // T1: rate 1088 (136 B), 5 full beats, last on the 5th
    start_msg(1088);
    check("t1_ready_absorb", t_ready_o, 1);
    for (int i = 0; i < 4; i++) send_beat(mk_data(i * 32), 32, 1'b0);
    check("t1_count_128", bytes_absorbed_o, 128);
    d5 = mk_data(128);
    send_beat(d5, 32, 1'b1);
    check("t1_perm_req",   perm_req_o,       1);
    check("t1_perm_ready", t_ready_o,        0);
    check("t1_perm_count", bytes_absorbed_o, 0);
    check("t1_perm_keep",  keep_o,           0);
    tick(); tick(); tick();
    check("t1_perm_held",  perm_req_o,       1);
    pulse_perm_done();
    check("t1_carry_keep", keep_o,      32'h00FF_FFFF);
    check("t1_carry_en",   absorb_en_o, 1);
    check("t1_carry_msg",  msg_o,       d5 >> 64);
    check("t1_carry_nreq", perm_req_o,  0);
    tick();
    check("t1_pad_req",    pad_req_o,        1);
    check("t1_pad_bytes",  pad_bytes_o,      24);
    check("t1_pad_count",  bytes_absorbed_o, 24);
    check("t1_pad_msg",    msg_o,            0);
    tick(); tick();
    check("t1_pad_stable", pad_bytes_o, 24);
    pulse_pad_ack();
    check("t1_idle_pad",   pad_req_o,        0);
    check("t1_idle_count", bytes_absorbed_o, 0);

    // T2: 4 x 32 B + 8 B last fills the block exactly
    start_msg(1088);
    for (int i = 0; i < 4; i++) send_beat(mk_data(64 + i), 32, 1'b0);
    send_beat(mk_data(7), 8, 1'b1);
    check("t2_perm_req", perm_req_o, 1);
    pulse_perm_done();
    check("t2_pad_now",    pad_req_o,   1);
    check("t2_pad_bytes",  pad_bytes_o, 0);
    check("t2_no_absorb",  absorb_en_o, 0);
    pulse_pad_ack();

    // T3: rate 576 (72 B): 32 + 32 + 32 last -> 24 B carry
    start_msg(576);
    send_beat(mk_data(1), 32, 1'b0);
    send_beat(mk_data(2), 32, 1'b0);
    check("t3_count_64", bytes_absorbed_o, 64);
    send_beat(mk_data(3), 32, 1'b1);
    check("t3_perm_req", perm_req_o, 1);
    pulse_perm_done();
    check("t3_carry_keep", keep_o, 32'h00FF_FFFF);
    tick();
    check("t3_pad_bytes", pad_bytes_o, 24);
    pulse_pad_ack();

    // T4: empty message
    p_base = perm_cyc;
    start_msg(1088);
    send_beat('0, 0, 1'b1);
    check("t4_pad_req",   pad_req_o,         1);
    check("t4_pad_bytes", pad_bytes_o,       0);
    check("t4_no_perm",   perm_cyc - p_base, 0);
    pulse_pad_ack();

    // T5: sixth beat held valid across a long permutation
    a_base = acc_cnt;
    start_msg(1088);
    for (int i = 0; i < 4; i++) send_beat(mk_data(i * 32), 32, 1'b0);
    check("t5_count_128", bytes_absorbed_o, 128);
    send_beat(mk_data(128), 32, 1'b0);
    check("t5_perm_count", bytes_absorbed_o, 0);
    d6 = mk_data(200);
    fork
      send_beat(d6, 32, 1'b1);
      begin
        for (int c = 0; c < 24; c++) begin
          check("t5_perm_backpressure", t_ready_o, 0);
          tick();
        end
        pulse_perm_done();
        check("t5_carry_keep",  keep_o,    32'h00FF_FFFF);
        check("t5_carry_ready", t_ready_o, 0);
      end
    join
    check("t5_pad_req",     pad_req_o,       1);
    check("t5_pad_bytes",   pad_bytes_o,     56);
    check("t5_beats_taken", acc_cnt - a_base, 6);
    pulse_pad_ack();

    // T6: reset during PERMUTE with carry pending
    start_msg(1088);
    for (int i = 0; i < 5; i++) send_beat(mk_data(i * 32), 32, 1'b0);
    check("t6_perm_req", perm_req_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("t6_reset");
    pulse_perm_done();  // no permutation is outstanding any more
    check("t6_no_carry_keep", keep_o,      0);
    check("t6_no_carry_en",   absorb_en_o, 0);
    start_msg(1088);
    check("t6_new_count", bytes_absorbed_o, 0);
    send_beat(mk_data(9), 32, 1'b1);
    check("t6_pad_bytes", pad_bytes_o, 32);
    pulse_pad_ack();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
